// File: rtl/fetch_controller.sv
// PC sequencing and instruction fetch over a req/ack memory port.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_controller #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Jump,
    input  logic        PCSrc,
    input  logic [15:0] Instr15_0,
    input  logic [25:0] Instr25_0,
    input  logic        Stall,
    input  logic        IMemAck,
    input  logic [31:0] IMemRdata,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic        FetchErr,
    output logic [1:0]  DbgState
);

    // Handshake: a fetch completes on the cycle IMemReq=1 and IMemAck=1;
    // IMemAck at any other time is ignored.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;

    logic [31:0] pc_plus4;
    logic [31:0] pc_branch;
    logic [31:0] pc_jump;
    logic [31:0] next_pc;

    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        pc_branch = pc_plus4 + {{14{Instr15_0[15]}}, Instr15_0, 2'b00};
        pc_jump   = {pc_plus4[31:28], Instr25_0, 2'b00};
        next_pc   = pc_plus4;
        if (Jump) begin
            next_pc = pc_jump;
        end else if (PCSrc) begin
            next_pc = pc_branch;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned       CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (IMemAck) begin
                        instr_q <= IMemRdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= S_EXEC;
`ifdef FETCH_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
`ifdef FETCH_TIMEOUT_EN
                    // A late ack on the last allowed cycle still wins over the timeout.
                    else if (cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                S_EXEC: begin
                    if (!Stall) begin
                        pc_q    <= next_pc;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_ERR: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign IMemReq    = req_q;
    assign IMemAddr   = pc_q;
    assign PC         = pc_q;
    assign Instr      = instr_q;
    assign InstrValid = valid_q;
    assign DbgState   = state_q;

`ifdef FETCH_TIMEOUT_EN
    assign FetchErr = err_q;
`else
    // Without the timeout the error state is unreachable; the parameter is kept for a uniform interface.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign FetchErr       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: transaction-level PC model, per-cycle compare
// process and an instruction scoreboard queue.
module tb_fetch_controller;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFFC;
  localparam int          TMO     = 16;

  logic        Clk;
  logic        Rst_n;
  logic        Jump;
  logic        PCSrc;
  logic [15:0] Instr15_0;
  logic [25:0] Instr25_0;
  logic        Stall;
  logic        IMemAck;
  logic [31:0] IMemRdata;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        FetchErr;
  logic [1:0]  DbgState;

  logic        req2;
  logic [31:0] addr2;
  logic [31:0] pc2;
  logic [31:0] instr2;
  logic        valid2;
  logic        err2;
  logic [1:0]  dbg2;

  fetch_controller #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Jump(Jump), .PCSrc(PCSrc),
    .Instr15_0(Instr15_0), .Instr25_0(Instr25_0), .Stall(Stall),
    .IMemAck(IMemAck), .IMemRdata(IMemRdata), .IMemReq(IMemReq),
    .IMemAddr(IMemAddr), .PC(PC), .Instr(Instr), .InstrValid(InstrValid),
    .FetchErr(FetchErr), .DbgState(DbgState)
  );

  // Second instance starting at the top of the address space, always acked.
  fetch_controller #(.RESET_PC(RST_PC2), .TIMEOUT_CYCLES(TMO)) u_dut_wrap (
    .Clk(Clk), .Rst_n(Rst_n), .Jump(1'b0), .PCSrc(1'b0),
    .Instr15_0(16'h0000), .Instr25_0(26'h0), .Stall(1'b0),
    .IMemAck(1'b1), .IMemRdata(32'h1234_5678), .IMemReq(req2),
    .IMemAddr(addr2), .PC(pc2), .Instr(instr2), .InstrValid(valid2),
    .FetchErr(err2), .DbgState(dbg2)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          chk_en   = 0;
  logic [31:0] model_pc;
  logic        exp_req;
  logic        exp_valid;
  logic        exp_err;
  logic [31:0] exp_q[$];
  logic [31:0] cur_instr;
  logic        prev_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next-PC rule in plain integer arithmetic modulo 2^32.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input bit j, input bit b,
                                             input logic [15:0] imm, input logic [25:0] tgt);
    longint p4;
    longint r;
    p4 = (longint'(pc) + 4) % 64'sh1_0000_0000;
    if (j) r = (p4 & 64'sh0_F000_0000) + longint'(tgt) * 4;
    else if (b) r = (p4 + 64'sh1_0000_0000 + longint'($signed(imm)) * 4) % 64'sh1_0000_0000;
    else r = p4;
    return r[31:0];
  endfunction

  // scoreboard / compare process
  always @(negedge Clk) begin
    if (!Rst_n) begin
      prev_valid = 1'b0;
    end else if (chk_en) begin
      chk("imem_req", {31'd0, IMemReq}, {31'd0, exp_req});
      chk("instr_valid", {31'd0, InstrValid}, {31'd0, exp_valid});
      chk("pc", PC, model_pc);
      chk("fetch_err", {31'd0, FetchErr}, {31'd0, exp_err});
      if (exp_req) chk("imem_addr", IMemAddr, model_pc);
      if (InstrValid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL instr_q: got unexpected InstrValid expected empty queue at %0t", $time);
        end else begin
          cur_instr = exp_q.pop_front();
        end
      end
      if (InstrValid) chk("instr", Instr, cur_instr);
      prev_valid = InstrValid;
    end
  end

  // driver tasks
  task automatic apply_reset();
    chk_en  = 0;
    Rst_n   = 1'b0;
    IMemAck = 1'b0;
    Stall   = 1'b0;
    Jump    = 1'b0;
    PCSrc   = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    exp_q.delete();
    model_pc  = RST_PC;
    exp_req   = 1'b0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    Rst_n     = 1'b1;
    chk_en    = 1;
    @(posedge Clk);
    #1;
    exp_req = 1'b1;
  endtask

  task automatic randomize_ignored();
    Jump      = 1'($urandom);
    PCSrc     = 1'($urandom);
    Instr15_0 = 16'($urandom);
    Instr25_0 = 26'($urandom);
  endtask

  // Entered just after the edge that put the DUT in FETCH; returns the same way.
  task automatic run_instr(input int wait_cyc, input int stall_cyc, input bit j, input bit b,
                           input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    for (int k = 0; k < wait_cyc; k++) begin
      IMemAck   = 1'b0;
      IMemRdata = $urandom;
      Stall     = 1'($urandom);
      randomize_ignored();
      @(posedge Clk);
      #1;
    end
    w         = $urandom;
    IMemAck   = 1'b1;
    IMemRdata = w;
    exp_q.push_back(w);
    randomize_ignored();
    @(posedge Clk);
    #1;
    exp_req   = 1'b0;
    exp_valid = 1'b1;
    for (int k = 0; k < stall_cyc; k++) begin
      Stall     = 1'b1;
      IMemAck   = 1'($urandom);
      IMemRdata = $urandom;
      randomize_ignored();
      @(posedge Clk);
      #1;
    end
    Stall     = 1'b0;
    IMemAck   = 1'($urandom);
    Jump      = j;
    PCSrc     = b;
    Instr15_0 = imm;
    Instr25_0 = tgt;
    @(posedge Clk);
    #1;
    model_pc  = model_next(model_pc, j, b, imm, tgt);
    exp_req   = 1'b1;
    exp_valid = 1'b0;
    IMemAck   = 1'b0;
  endtask

  task automatic pin(input string name, input logic [31:0] lit);
    chk(name, PC, lit);
    chk({name, "_model"}, model_pc, lit);
  endtask

  initial begin
    Rst_n     = 1'b0;
    Jump      = 1'b0;
    PCSrc     = 1'b0;
    Stall     = 1'b0;
    IMemAck   = 1'b0;
    IMemRdata = '0;
    Instr15_0 = '0;
    Instr25_0 = '0;
    model_pc  = RST_PC;
    exp_req   = 1'b0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    cur_instr = '0;
    prev_valid = 1'b0;

    // reset values
    @(posedge Clk);
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_addr", IMemAddr, 32'h0);
    chk("rst_req", {31'd0, IMemReq}, 32'd0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_err", {31'd0, FetchErr}, 32'd0);
    chk("rst_pc_wrap", pc2, 32'hFFFF_FFFC);

    // PC wrap from the top of the address space
    Rst_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("wrap_valid", {31'd0, valid2}, 32'd1);
    chk("wrap_pc_exec", pc2, 32'hFFFF_FFFC);
    chk("wrap_instr", instr2, 32'h1234_5678);
    @(posedge Clk);
    #1;
    chk("wrap_pc_next", pc2, 32'h0000_0000);
    chk("wrap_req", {31'd0, req2}, 32'd1);
    chk("wrap_valid_low", {31'd0, valid2}, 32'd0);

    // sequential fetch, ack on first FETCH cycle
    apply_reset();
    run_instr(0, 0, 0, 0, 16'h0, 26'h0);
    pin("seq_pc4", 32'h4);
    run_instr(0, 0, 0, 0, 16'h0, 26'h0);
    pin("seq_pc8", 32'h8);
    run_instr(0, 0, 0, 0, 16'h0, 26'h0);
    pin("seq_pcC", 32'hC);
    run_instr(0, 0, 0, 0, 16'h0, 26'h0);

    // branches from 0x40
    run_instr(1, 0, 1, 0, 16'h0, 26'h10);
    pin("jmp_40", 32'h40);
    run_instr(0, 0, 0, 1, 16'hFFFE, 26'h0);
    pin("br_back_3C", 32'h3C);
    run_instr(2, 0, 1, 0, 16'h0, 26'h10);
    run_instr(0, 0, 0, 1, 16'h0003, 26'h0);
    pin("br_fwd_50", 32'h50);

    // jump priority over branch, upper nibble from PC+4
    run_instr(0, 0, 1, 0, 16'h0, 26'h3FF_FFFF);
    pin("jmp_0FFFFFFC", 32'h0FFF_FFFC);
    run_instr(0, 0, 0, 0, 16'h0, 26'h0);
    run_instr(0, 0, 0, 0, 16'h0, 26'h0);
    run_instr(0, 0, 0, 0, 16'h0, 26'h0);
    pin("pc_10000008", 32'h1000_0008);
    run_instr(0, 0, 1, 1, 16'h1234, 26'h0000100);
    pin("jmp_prio", 32'h1000_0400);

    // stall holds for three cycles, then advances; then last-cycle ack
    run_instr(0, 3, 0, 0, 16'h0, 26'h0);
    pin("stall_adv", 32'h1000_0404);
    run_instr(TMO - 1, 0, 0, 0, 16'h0, 26'h0);
    pin("late_ack", 32'h1000_0408);

    // randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      int wc;
      wc = ($urandom_range(0, 9) == 0) ? (TMO - 1) : $urandom_range(0, 3);
      run_instr(wc, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                16'($urandom), 26'($urandom));
    end

    // no ack at all
    IMemAck = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    repeat (TMO - 1) begin
      @(posedge Clk);
      #1;
    end
    @(posedge Clk);
    #1;
    exp_req = 1'b0;
    exp_err = 1'b1;
    repeat (6) begin
      IMemAck = 1'($urandom);
      @(posedge Clk);
      #1;
    end
    chk("err_sticky", {31'd0, FetchErr}, 32'd1);
`else
    repeat (40) begin
      @(posedge Clk);
      #1;
    end
    chk("wait_forever_req", {31'd0, IMemReq}, 32'd1);
`endif

    // reset asserted in the middle of a FETCH
    apply_reset();
    run_instr(0, 0, 0, 0, 16'h0, 26'h0);
    IMemAck = 1'b0;
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    chk("pre_rst_pc", PC, 32'h4);
    chk_en = 0;
    Rst_n  = 1'b0;
    #1;
    chk("midrst_req", {31'd0, IMemReq}, 32'd0);
    chk("midrst_pc", PC, RST_PC);
    chk("midrst_valid", {31'd0, InstrValid}, 32'd0);
    chk("midrst_err", {31'd0, FetchErr}, 32'd0);
    apply_reset();
    run_instr(1, 1, 0, 0, 16'h0, 26'h0);
    pin("post_rst_pc", 32'h4);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
